// File: rtl/spi_pkg.sv
// Purpose: shared types and constants for the SPI-to-register bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WRITE = 3'd2,
        FETCH = 3'd3,
        READ  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int          CMD_READ_BIT    = 7;
    localparam logic [7:0]  STATUS_BYTE_DEF = 8'hA5;
    localparam logic [7:0]  ERR_FILL        = 8'hFF;

    // True when any bit between the address field and the read flag is set.
    function automatic logic cmd_rsvd_set(input logic [7:0] cmd, input int addr_w);
        return |(cmd[6:0] >> addr_w);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: generic two-flop synchroniser for a single pad input into the local clock.
// Latency: 2 clock cycles from input change to output change.
// Backpressure: none; level signal, always sampled.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; both load RST_VAL while reset is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_bridge.sv
// Purpose: parses CSN-framed SPI bytes into auto-incrementing register writes/reads.
// Latency: write strobe 1 cycle after rx_done; read data on tx_data 2 cycles after rx_done.
// Backpressure: none; every rx_done is consumed or deliberately dropped (IDLE/ERR/frame end).
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              csn_pad,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              frame_active,
    output logic              cmd_err
);

    state_t r_state;
    logic   r_csn_prev;
    logic   r_armed;
    logic   r_fetch_cap;

    logic   w_csn_sync;
    logic   w_settled;
    logic   w_fall;
    logic   w_rise;
    logic   w_rsvd;

    sync_2ff #(.RST_VAL(1'b1)) u_csn_sync (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_d   (csn_pad),
        .o_q   (w_csn_sync)
    );

    // Goes high two cycles after reset release, once the CSN synchroniser
    // reflects the real pad level rather than its reset value.
    sync_2ff #(.RST_VAL(1'b0)) u_rst_settle (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_d   (1'b1),
        .o_q   (w_settled)
    );

    // A falling edge only counts once CSN has been seen high after reset, so a
    // frame already in progress at reset release is never picked up mid-way.
    assign w_fall       = r_armed & r_csn_prev & ~w_csn_sync;
    assign w_rise       = ~r_csn_prev & w_csn_sync;
    assign w_rsvd       = cmd_rsvd_set(rx_data, ADDR_W);
    assign frame_active = ~w_csn_sync;

    // Edge history and post-reset arming for the synchronised chip-select.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_csn_prev <= 1'b1;
            r_armed    <= 1'b0;
        end else begin
            r_csn_prev <= w_csn_sync;
            r_armed    <= r_armed | (w_settled & w_csn_sync);
        end
    end

    // Transaction FSM with registered strobes, address and tx byte.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_fetch_cap <= 1'b0;
            tx_data     <= STATUS_BYTE;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wdata   <= 8'h00;
            reg_rd_en   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            if (w_rise) begin
                // Frame end wins over any rx_done arriving in the same cycle.
                r_state <= IDLE;
                tx_data <= STATUS_BYTE;
            end else begin
                case (r_state)
                    IDLE: begin
                        tx_data <= STATUS_BYTE;
                        if (w_fall) begin
                            r_state <= CMD;
                            cmd_err <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (rx_done) begin
                            reg_addr <= rx_data[ADDR_W-1:0];
                            if (w_rsvd) begin
                                r_state <= ERR;
                                cmd_err <= 1'b1;
                                tx_data <= ERR_FILL;
                            end else if (rx_data[CMD_READ_BIT]) begin
                                r_state     <= FETCH;
                                reg_rd_en   <= 1'b1;
                                r_fetch_cap <= 1'b0;
                            end else begin
                                r_state <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        // Advance the address the cycle after each strobe; a
                        // strobe issued on this same edge then sees the new one.
                        if (reg_wr_en) begin
                            reg_addr <= reg_addr + 1'b1;
                        end
                        if (rx_done) begin
                            reg_wr_en <= 1'b1;
                            reg_wdata <= rx_data;
                            tx_data   <= rx_data;
                        end
                    end
                    FETCH: begin
                        // First cycle carries the read strobe, second captures data.
                        if (r_fetch_cap) begin
                            tx_data <= reg_rdata;
                            r_state <= READ;
                        end
                        r_fetch_cap <= 1'b1;
                    end
                    READ: begin
                        if (rx_done) begin
                            reg_addr    <= reg_addr + 1'b1;
                            reg_rd_en   <= 1'b1;
                            r_fetch_cap <= 1'b0;
                            r_state     <= FETCH;
                        end
                    end
                    ERR: begin
                        tx_data <= ERR_FILL;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of spi_peripheral_v5. Consumes its RX_DONE/RX_DATA byte stream and drives its D_TO_SEND input.
- Parses each CSN-framed transaction as a command byte followed by data bytes.
- Performs auto-incrementing 8-bit register writes and reads on a simple synchronous register bus feeding the DSP/ADC control registers.
- Returns a status byte while the command byte is being clocked in.

Parameters:
- ADDR_W, 4, register address width; 2^ADDR_W registers, wrap-around addressing.
- STATUS_BYTE, 8'hA5, value presented on tx_data during the command byte.

Ports:
- sys_clk, input, 1, system clock (48 MHz).
- sys_rst, input, 1, asynchronous active-high reset.
- csn_pad, input, 1, raw SPI chip-select, active low; synchronised internally.
- rx_done, input, 1, one-cycle pulse from spi_peripheral_v5 marking a received byte.
- rx_data, input, 8, received byte; valid while rx_done=1.
- tx_data, output, 8, byte for the next SPI transfer; connects to D_TO_SEND.
- reg_addr, output, ADDR_W, register bus address.
- reg_wr_en, output, 1, one-cycle write strobe.
- reg_wdata, output, 8, write data.
- reg_rd_en, output, 1, one-cycle read strobe.
- reg_rdata, input, 8, read data; valid exactly one cycle after reg_rd_en.
- frame_active, output, 1, synchronised CSN low.
- cmd_err, output, 1, sticky flag for a bad command in the current/last frame.

Behaviour:
- Reset (async, sys_rst=1): state=IDLE; tx_data=STATUS_BYTE; reg_addr=0; reg_wr_en=0; reg_rd_en=0; reg_wdata=0; frame_active=0; cmd_err=0; CSN synchroniser flops=1.
- CSN sync: 2-flop synchroniser; frame_active = ~csn_sync; 2-cycle latency. A synchronised rising edge (frame end) forces IDLE from any state the same cycle.
- Command byte format: bit7 = read(1)/write(0); bits[ADDR_W-1:0] = start address; bits[6:ADDR_W] must be 0.
- State machine:
  - IDLE: tx_data=STATUS_BYTE. Enter CMD on csn_sync falling edge; clear cmd_err there.
  - CMD: on rx_done, latch address into reg_addr.
    - Reserved bits nonzero -> ERR; set cmd_err.
    - Read -> FETCH.
    - Write -> WRITE.
  - WRITE: each rx_done -> next cycle reg_wr_en=1, reg_wdata=rx_data, reg_addr=current address; the cycle after the strobe, address increments. tx_data = last received byte (echo).
  - FETCH: cycle 1 reg_rd_en=1; cycle 2 tx_data<=reg_rdata; then -> READ.
    - tx_data must be valid no later than 3 sys_clk cycles after the rx_done that triggered the fetch (fits within one SCK half-period at 8 MHz).
  - READ: on rx_done, address<=address+1, -> FETCH.
  - ERR: ignore all rx_done; tx_data=8'hFF until frame end.
- Address arithmetic: modulo 2^ADDR_W; 4'hF+1 -> 4'h0, no flag.
- Strobes: reg_wr_en and reg_rd_en are never high together; each is high at most one cycle per byte.
- rx_done while IDLE (CSN high or not yet synchronised): ignored.
- rx_done in the same cycle as the frame-end edge: ignored. No write is issued and no address is incremented.
- Frame end mid-FETCH: abort; an already-issued reg_rd_en is harmless; tx_data returns to STATUS_BYTE.
- Back-to-back frames with CSN high for >=3 sys_clk cycles must be handled; shorter gaps are not required to be detected.
- sys_rst mid-frame: immediate return to reset values. The block resumes only on the next CSN falling edge seen after reset release.

Decomposition:
- Shared package spi_pkg:
  - state encoding constants (IDLE, CMD, WRITE, FETCH, READ, ERR);
  - CMD_READ_BIT=7;
  - default STATUS_BYTE;
  - ERR_FILL=8'hFF.
- Sub-module sync_2ff (generic 2-flop synchroniser with reset value parameter), reused for any pad input crossing into sys_clk.

Test Plan:
- Write burst: CSN low; bytes 8'h03,8'h11,8'h22,8'h33; CSN high -> writes 11@3, 22@4, 33@5; each reg_wr_en is 1 cycle; cmd_err=0.
- Read burst: regs preloaded 3=8'hAA, 4=8'hBB; bytes 8'h83,x,x -> tx_data STATUS_BYTE during byte 1, then 8'hAA, 8'hBB; tx_data valid <=3 cycles after each rx_done.
- Wrap: write cmd 8'h0F with 2 data bytes 8'h5A,8'hC3 -> writes 5A@F, C3@0.
- Bad command: 8'h40 then 8'h12 -> cmd_err=1, no reg_wr_en, tx_data=8'hFF; next frame clears cmd_err.
- Abort: read cmd 8'h82, CSN raised 1 cycle after rx_done -> at most one reg_rd_en, state IDLE, tx_data=STATUS_BYTE; rx_done coincident with frame-end edge produces no write.
- Reset mid-write frame (sys_rst pulsed after the command byte) -> all outputs at reset values immediately; subsequent data bytes in the same frame produce no writes.
